// File: rtl/merge_pkg.sv
// Shared defaults and FSM encoding for the two-block streaming merger.
// Optional unsorted-input detection is enabled with MERGE_ORDER_CHECK_EN.
package merge_pkg;

    localparam int MERGE_W_DEF = 8;
    localparam int MERGE_N_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

endpackage

// File: rtl/merge_select.sv
// Picks the next merged element from the heads of blocks A and B.
module merge_select
    import merge_pkg::*;
#(
    parameter int W = MERGE_W_DEF
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         a_done_i,
    input  logic         b_done_i,
    output logic [W-1:0] val_o,
    output logic         take_a_o
);

    // Ties go to A so equal keys keep A-before-B order.
    assign take_a_o = b_done_i | (~a_done_i & (a_i <= b_i));
    assign val_o    = take_a_o ? a_i : b_i;

endmodule

// File: rtl/merge_stream.sv
// Merges two sorted N-element blocks into one 2N-element output stream.
// Define MERGE_ORDER_CHECK_EN to add the registered order_err flag.
module merge_stream
    import merge_pkg::*;
#(
    parameter int W = MERGE_W_DEF,
    parameter int N = MERGE_N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] a_data,
    input  logic [N*W-1:0] b_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last
`ifdef MERGE_ORDER_CHECK_EN
    ,
    output logic           order_err
`endif
);

    localparam int IW = $clog2(N + 1);

    state_t              state_q, state_d;
    logic [N-1:0][W-1:0] a_q, b_q;
    logic [IW-1:0]       ia_q, ia_d, ib_q, ib_d;
    logic [IW:0]         consumed;
    logic [W-1:0]        elem_a, elem_b, sel_val;
    logic                a_done, b_done, take_a, xfer_in, xfer_out;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;
    assign a_done   = (ia_q == IW'(N));
    assign b_done   = (ib_q == IW'(N));
    assign consumed = {1'b0, ia_q} + {1'b0, ib_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MERGE;
            MERGE:   if (out_ready && out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == MERGE);
        out_data  = out_valid ? sel_val : '0;
        out_last  = out_valid && (consumed == (IW+1)'(2*N - 1));
    end

    // Exhausted heads read as zero; the selector ignores them via the done flags.
    always_comb begin
        elem_a = '0;
        elem_b = '0;
        for (int k = 0; k < N; k++) begin
            if (ia_q == IW'(k)) elem_a = a_q[k];
            if (ib_q == IW'(k)) elem_b = b_q[k];
        end
    end

    merge_select #(.W(W)) u_sel (
        .a_i      (elem_a),
        .b_i      (elem_b),
        .a_done_i (a_done),
        .b_done_i (b_done),
        .val_o    (sel_val),
        .take_a_o (take_a)
    );

    always_comb begin
        ia_d = ia_q;
        ib_d = ib_q;
        if (xfer_in) begin
            ia_d = '0;
            ib_d = '0;
        end else if (xfer_out) begin
            if (take_a) ia_d = ia_q + 1'b1;
            else        ib_d = ib_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            ia_q <= '0;
            ib_q <= '0;
        end else begin
            ia_q <= ia_d;
            ib_q <= ib_d;
            if (xfer_in) begin
                a_q <= a_data;
                b_q <= b_data;
            end
        end
    end

`ifdef MERGE_ORDER_CHECK_EN
    logic [N-1:0][W-1:0] a_in, b_in;
    logic                unsorted, order_err_q;

    assign a_in = a_data;
    assign b_in = b_data;

    always_comb begin
        unsorted = 1'b0;
        for (int k = 0; k + 1 < N; k++)
            if ((a_in[k+1] < a_in[k]) || (b_in[k+1] < b_in[k])) unsorted = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       order_err_q <= 1'b0;
        else if (xfer_in) order_err_q <= unsorted;
    end

    assign order_err = order_err_q;
`endif

endmodule

// File: tb/tb_merge_stream.sv
// Randomized and directed bench for merge_stream against a queue-based merge model.
module tb_merge_stream;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic           in_ready, out_valid, out_last;
    logic [N*W-1:0] a_data = '0, b_data = '0;
    logic [W-1:0]   out_data;
`ifdef MERGE_ORDER_CHECK_EN
    logic           order_err;
`endif

    int n_cmp = 0, n_err = 0;

    logic [W-1:0] got_d[$], exp_d[$];
    bit           got_l[$], got_ta[$], exp_ta[$];
    bit           got_first_valid, timed_out, exp_err;
    int           stall_bad, busy_bad, cycles;

    always #5 clk = ~clk;

    merge_stream #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_data    (a_data),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef MERGE_ORDER_CHECK_EN
        ,
        .order_err (order_err)
`endif
    );

    function automatic logic [N*W-1:0] pack4(input int e0, e1, e2, e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    // Reference: two-pointer merge over queues, ties to A, plus adjacent-pair order check.
    task automatic model(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        logic [W-1:0] qa[$], qb[$];
        exp_d.delete(); exp_ta.delete(); exp_err = 0;
        for (int k = 0; k < N; k++) begin
            qa.push_back(a[k*W +: W]);
            qb.push_back(b[k*W +: W]);
            if (k > 0 && (a[k*W +: W] < a[(k-1)*W +: W] || b[k*W +: W] < b[(k-1)*W +: W])) exp_err = 1;
        end
        while (qa.size() + qb.size() > 0) begin
            if (qb.size() == 0 || (qa.size() > 0 && qa[0] <= qb[0])) begin
                exp_d.push_back(qa.pop_front()); exp_ta.push_back(1'b1);
            end else begin
                exp_d.push_back(qb.pop_front()); exp_ta.push_back(1'b0);
            end
        end
    endtask

    task automatic send(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        @(negedge clk);
        in_valid = 1'b1; a_data = a; b_data = b;
        @(posedge clk); #1;
        in_valid = 1'b0; a_data = ~a; b_data = ~b;
    endtask

    // mode 0: ready always, 1: ready toggles 1,0,..., 2: random ready
    task automatic collect(input int mode, input int max_x);
        logic [W-1:0] prev_d;
        bit prev_stall;
        int nx;
        got_d.delete(); got_l.delete(); got_ta.delete();
        stall_bad = 0; busy_bad = 0; timed_out = 1; prev_stall = 0; nx = 0; cycles = 0;
        prev_d = '0; got_first_valid = 0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? c[0] : 1'($urandom_range(0, 1));
            if (c == 1) got_first_valid = out_valid;
            if (out_valid && in_ready) busy_bad++;
            if (prev_stall && out_data !== prev_d) stall_bad++;
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data); got_l.push_back(out_last); got_ta.push_back(dut.take_a);
                nx++;
                if (out_last || nx == max_x) begin cycles = c; timed_out = 0; break; end
            end
        end
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset.in_ready got %b exp 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset.out_last got %b exp 0", out_last); end
        n_cmp++; if (out_data !== 8'd0) begin n_err++; $display("FAIL reset.out_data got %0d exp 0", out_data); end
`ifdef MERGE_ORDER_CHECK_EN
        n_cmp++; if (order_err !== 1'b0) begin n_err++; $display("FAIL reset.order_err got %b exp 0", order_err); end
`endif
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int exp[8] = '{1, 2, 3, 4, 5, 6, 7, 9};
        send(pack4(2, 3, 5, 9), pack4(1, 4, 6, 7));
        collect(0, 99);
        n_cmp++; if (timed_out || got_d.size() != 8) begin n_err++; $display("FAIL basic.count got %0d exp 8", got_d.size()); end
        n_cmp++; if (got_first_valid !== 1'b1) begin n_err++; $display("FAIL basic.latency out_valid got %b exp 1", got_first_valid); end
        n_cmp++; if (cycles != 8) begin n_err++; $display("FAIL basic.cycles got %0d exp 8", cycles); end
        for (int i = 0; i < got_d.size() && i < 8; i++) begin
            n_cmp++; if (got_d[i] !== 8'(exp[i])) begin n_err++; $display("FAIL basic.data[%0d] got %0d exp %0d", i, got_d[i], exp[i]); end
            n_cmp++; if (got_l[i] !== (i == 7)) begin n_err++; $display("FAIL basic.last[%0d] got %b exp %b", i, got_l[i], i == 7); end
        end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL basic.idle in_ready %b out_valid %b exp 1 0", in_ready, out_valid); end
    endtask

    task automatic test_ties();
        send(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5));
        collect(0, 99);
        n_cmp++; if (timed_out || got_d.size() != 8) begin n_err++; $display("FAIL ties.count got %0d exp 8", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 8; i++) begin
            n_cmp++; if (got_d[i] !== 8'd5) begin n_err++; $display("FAIL ties.data[%0d] got %0d exp 5", i, got_d[i]); end
            n_cmp++; if (got_ta[i] !== (i < 4)) begin n_err++; $display("FAIL ties.take_a[%0d] got %b exp %b", i, got_ta[i], i < 4); end
        end
    endtask

    task automatic test_backpressure();
        send(pack4(5, 5, 5, 5), pack4(5, 5, 5, 5));
        collect(1, 99);
        n_cmp++; if (timed_out || got_d.size() != 8) begin n_err++; $display("FAIL bp.count got %0d exp 8", got_d.size()); end
        n_cmp++; if (cycles != 15) begin n_err++; $display("FAIL bp.cycles got %0d exp 15", cycles); end
        n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL bp.stable got %0d changes exp 0", stall_bad); end
        n_cmp++; if (busy_bad != 0) begin n_err++; $display("FAIL bp.in_ready got %0d busy cycles high exp 0", busy_bad); end
        n_cmp++; if (got_l.size() == 8 && got_l[7] !== 1'b1) begin n_err++; $display("FAIL bp.last got %b exp 1", got_l[7]); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp.in_ready_after got %b exp 1", in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [N*W-1:0] a, b;
        send(pack4(2, 3, 5, 9), pack4(1, 4, 6, 7));
        collect(0, 3);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid.out_valid got %b exp 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid.in_ready got %b exp 1", in_ready); end
        n_cmp++; if (out_data !== 8'd0) begin n_err++; $display("FAIL rstmid.out_data got %0d exp 0", out_data); end
        @(negedge clk); rst_n = 1'b1;
        a = pack4(10, 20, 30, 40); b = pack4(15, 25, 35, 45);
        model(a, b);
        send(a, b);
        collect(0, 99);
        n_cmp++; if (timed_out || got_d.size() != 8) begin n_err++; $display("FAIL rstmid.count got %0d exp 8", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 8; i++) begin
            n_cmp++; if (got_d[i] !== exp_d[i]) begin n_err++; $display("FAIL rstmid.data[%0d] got %0d exp %0d", i, got_d[i], exp_d[i]); end
        end
    endtask

    task automatic test_extremes();
        send(pack4(0, 0, 0, 0), pack4(255, 255, 255, 255));
        collect(0, 99);
        n_cmp++; if (timed_out || got_d.size() != 8) begin n_err++; $display("FAIL ext.count got %0d exp 8", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 8; i++) begin
            n_cmp++; if (got_d[i] !== ((i < 4) ? 8'd0 : 8'd255)) begin n_err++; $display("FAIL ext.data[%0d] got %0d", i, got_d[i]); end
            n_cmp++; if (got_ta[i] !== (i < 4)) begin n_err++; $display("FAIL ext.take_a[%0d] got %b exp %b", i, got_ta[i], i < 4); end
            n_cmp++; if (got_l[i] !== (i == 7)) begin n_err++; $display("FAIL ext.last[%0d] got %b exp %b", i, got_l[i], i == 7); end
        end
    endtask

`ifdef MERGE_ORDER_CHECK_EN
    task automatic test_order_err();
        send(pack4(9, 3, 5, 2), pack4(1, 4, 6, 7));
        collect(0, 99);
        n_cmp++; if (order_err !== 1'b1) begin n_err++; $display("FAIL order.unsorted got %b exp 1", order_err); end
        send(pack4(2, 3, 5, 9), pack4(1, 4, 6, 7));
        collect(0, 99);
        n_cmp++; if (order_err !== 1'b0) begin n_err++; $display("FAIL order.sorted got %b exp 0", order_err); end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] qa[$], qb[$];
        logic [N*W-1:0] a, b;
        for (int it = 0; it < 24; it++) begin
            qa.delete(); qb.delete();
            for (int k = 0; k < N; k++) begin
                qa.push_back(8'($urandom_range(0, 15)));
                qb.push_back(8'($urandom_range(0, 15)));
            end
            if (it % 4 != 3) begin qa.sort(); qb.sort(); end
            for (int k = 0; k < N; k++) begin a[k*W +: W] = qa[k]; b[k*W +: W] = qb[k]; end
            model(a, b);
            send(a, b);
            collect(2, 99);
            n_cmp++; if (timed_out || got_d.size() != 8) begin n_err++; $display("FAIL rand%0d.count got %0d exp 8", it, got_d.size()); end
            n_cmp++; if (stall_bad != 0) begin n_err++; $display("FAIL rand%0d.stable got %0d changes exp 0", it, stall_bad); end
            for (int i = 0; i < got_d.size() && i < 8; i++) begin
                n_cmp++;
                if (got_d[i] !== exp_d[i] || got_ta[i] !== exp_ta[i] || got_l[i] !== (i == 7)) begin
                    n_err++;
                    $display("FAIL rand%0d.elem[%0d] got d=%0d a=%b l=%b exp d=%0d a=%b l=%b",
                             it, i, got_d[i], got_ta[i], got_l[i], exp_d[i], exp_ta[i], i == 7);
                end
            end
`ifdef MERGE_ORDER_CHECK_EN
            n_cmp++; if (order_err !== exp_err) begin n_err++; $display("FAIL rand%0d.order_err got %b exp %b", it, order_err, exp_err); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_backpressure();
        test_reset_mid();
        test_extremes();
`ifdef MERGE_ORDER_CHECK_EN
        test_order_err();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/merge_stream.md
MERGE_STREAM -- requirements
Module: merge_stream

Interface
REQ-001 SHALL have parameter W, default 8, element width in bits.
REQ-002 SHALL have parameter N, default 4, elements per input block (N >= 1).
REQ-003 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  block pair offered.
- in_ready  output  1  block pair can be accepted.
- a_data  input  N*W  sorted block A, element 0 at LSBs.
- b_data  input  N*W  sorted block B, element 0 at LSBs.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  W  merged element.
- out_last  output  1  marks the final (2N-th) element.
- order_err  output  1  unsorted-input flag; present only with MERGE_ORDER_CHECK_EN.

Function
REQ-004 SHALL implement an FSM with two states, IDLE and MERGE.
REQ-005 SHALL drive in_ready=1 in IDLE only; a transfer occurs when in_valid and in_ready are both 1 on a rising edge.
REQ-006 On transfer, SHALL capture a_data and b_data into internal registers, clear read indices ia and ib to 0, and enter MERGE.
REQ-007 In MERGE, SHALL hold out_valid=1; out_data SHALL be A[ia] if ib==N, B[ib] if ia==N, otherwise the smaller of A[ia] and B[ib] (unsigned compare).
REQ-008 On a tie, SHALL select A first (stable merge).
REQ-009 On out_valid and out_ready, SHALL increment the index of the selected source; out_data SHALL hold stable while out_ready=0.
REQ-010 SHALL assert out_last when ia+ib == 2N-1.
REQ-011 After the out_last transfer, SHALL return to IDLE, so in_ready=1 on the next cycle.
REQ-012 Latency: first out_valid SHALL occur one cycle after the input transfer; throughput SHALL be one element per cycle while out_ready=1.
REQ-013 Changes on a_data, b_data or in_valid during MERGE SHALL have no effect.
REQ-014 Output order is ascending only if each input block is non-decreasing; otherwise the output is the deterministic result of REQ-007/008.
REQ-015 Index counters SHALL be clog2(N+1) bits wide and SHALL never exceed N.

Reset
REQ-016 While rst_n=0: state SHALL be IDLE, in_ready=1, out_valid=0, out_last=0, out_data=0, indices=0, order_err=0.
REQ-017 Reset asserted mid-MERGE SHALL discard the block immediately; no further elements are emitted.

Configuration
REQ-018 With MERGE_ORDER_CHECK_EN defined: on each transfer, order_err SHALL be registered as 1 if any adjacent pair in A or B decreases, otherwise 0; it SHALL hold until the next transfer.
REQ-019 Without MERGE_ORDER_CHECK_EN: the order_err port and its logic SHALL be absent.

Structure
REQ-020 Defaults for W and N, and the FSM state encoding (IDLE=0, MERGE=1), SHALL live in shared package merge_pkg.
REQ-021 A combinational sub-module merge_select (inputs: two elements and two exhausted flags; outputs: value and take_a) SHALL implement REQ-007/008.

Verification
REQ-022 The bench SHALL cover these scenarios:
- A={2,3,5,9}, B={1,4,6,7}, out_ready=1: outputs 1,2,3,4,5,6,7,9 on consecutive cycles; out_last with 9.
- A={5,5,5,5}, B={5,5,5,5}: eight 5s, with all A elements taken first (internal take_a visible).
- Same A/B, out_ready toggling 1,0: out_data stable during stalls; exactly 8 transfers; in_ready=0 until after out_last.
- rst_n pulled low after third output: out_valid=0 immediately; in_ready=1; next block merges correctly.
- With MERGE_ORDER_CHECK_EN: A={9,3,5,2} gives order_err=1; then A={2,3,5,9} gives order_err=0.
- A={0,0,0,0}, B={255,255,255,255}: A exhausted first, then 255 x4; out_last on the 8th element.
